cdb_arbiter: RTL and testbench

//  Shares the N_CDB common-data-bus writeback ports among the execute-stage FU result registers (ALU0/1, MEM, AGU, MDU).

---
 rtl/cdb_arbiter_pkg.sv | 27 ++
 rtl/cdb_arbiter_if.sv | 26 ++
 rtl/cdb_arbiter_rr_picker.sv | 52 +++++
 rtl/cdb_arbiter.sv | 143 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared micro-architecture constants and the writeback packet carried on the CDB.
// Imported by the CDB arbiter, its interface and its round-robin picker.
package cdb_arbiter_pkg;

    localparam int NUM_FU    = 5;
    localparam int NUM_CDB   = 2;
    localparam int XLEN      = 32;
    localparam int ROB_TAG_W = 6;
    localparam int PREG_W    = 7;

    // Requester index equals the FU slot number.
    typedef enum logic [2:0] {
        FU_ALU0 = 3'd0,
        FU_ALU1 = 3'd1,
        FU_MEM  = 3'd2,
        FU_AGU  = 3'd3,
        FU_MDU  = 3'd4
    } fu_slot_e;

    typedef struct packed {
        logic                 is_valid;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [PREG_W-1:0]    dest_preg;
        logic [XLEN-1:0]      data;
    } writeback_packet_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-result / grant / broadcast bundle between the execute stage and the CDB arbiter.
// The execute stage is the master, the arbiter is the slave.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ = NUM_FU,
    parameter int N_CDB = NUM_CDB
) ();

    writeback_packet_t fu_results [N_REQ];
    logic [N_REQ-1:0]  fu_cdb_gnts;
    writeback_packet_t cdb_ports  [N_CDB];

    modport master (
        output fu_results,
        input  fu_cdb_gnts,
        input  cdb_ports
    );

    modport slave (
        input  fu_results,
        output fu_cdb_gnts,
        output cdb_ports
    );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin picker: rotate the request vector to start at 'start', priority-encode,
// then rotate the winner back. Requires N >= 2 and start < N.
module cdb_rr_picker #(
    parameter int N     = 5,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     pick,
    output logic             found
);

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input logic [IDX_W-1:0] off);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (IDX_W+1)'(N)) begin
            sum = sum - (IDX_W+1)'(N);
        end
        return sum[IDX_W-1:0];
    endfunction

    logic [N-1:0]     rotated;
    logic [IDX_W-1:0] rot_sel;

    always_comb begin
        rotated = '0;
        for (int j = 0; j < N; j++) begin
            rotated[j] = req[wrap_add(start, IDX_W'(j))];
        end
    end

    // Scanning downward leaves the lowest rotated position as the winner.
    always_comb begin
        found   = 1'b0;
        rot_sel = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                found   = 1'b1;
                rot_sel = IDX_W'(j);
            end
        end
    end

    always_comb begin
        pick = '0;
        if (found) begin
            pick[wrap_add(start, rot_sel)] = 1'b1;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Zero-latency CDB arbiter: round-robin over FU result registers with a starvation
// backstop; grants double as the FU output-register advance enables.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ        = NUM_FU,
    parameter int N_CDB        = NUM_CDB,
    parameter int STARVE_LIMIT = 7,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    cdb_arbiter_if.slave bus
);

    localparam int               IDX_W    = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] starve_cnt [N_REQ];

    logic             kill;
    logic [N_REQ-1:0] valid;
    logic [N_REQ-1:0] starved;
    logic [N_REQ-1:0] normal;

    logic [N_REQ-1:0] taken      [N_CDB+1];
    logic [N_REQ-1:0] s_pick     [N_CDB];
    logic [N_REQ-1:0] n_pick     [N_CDB];
    logic [N_REQ-1:0] port_pick  [N_CDB];
    logic             s_found    [N_CDB];
    logic             n_found    [N_CDB];
    logic             port_found [N_CDB];
    logic [IDX_W-1:0] port_idx   [N_CDB];

    logic             any_grant;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] next_rr;

    function automatic logic [IDX_W-1:0] onehot_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        kill = rst | flush;
        for (int i = 0; i < N_REQ; i++) begin
            valid[i]   = bus.fu_results[i].is_valid;
            starved[i] = bus.fu_results[i].is_valid && (starve_cnt[i] == CNT_MAX);
        end
        normal = valid & ~starved;
    end

    assign taken[0] = '0;

    // Each port takes the next starved requester if any remain, else the next normal one;
    // earlier ports' picks are masked out so no requester lands on two ports.
    for (genvar k = 0; k < N_CDB; k++) begin : g_port
        cdb_rr_picker #(.N(N_REQ)) u_starved (
            .req   (starved & ~taken[k]),
            .start (rr_ptr),
            .pick  (s_pick[k]),
            .found (s_found[k])
        );

        cdb_rr_picker #(.N(N_REQ)) u_normal (
            .req   (normal & ~taken[k]),
            .start (rr_ptr),
            .pick  (n_pick[k]),
            .found (n_found[k])
        );

        assign port_pick[k]  = s_found[k] ? s_pick[k] : n_pick[k];
        assign port_found[k] = s_found[k] | n_found[k];
        assign port_idx[k]   = onehot_idx(port_pick[k]);
        assign taken[k+1]    = taken[k] | port_pick[k];
    end

    always_comb begin
        any_grant = 1'b0;
        last_idx  = rr_ptr;
        for (int k = 0; k < N_CDB; k++) begin
            if (port_found[k]) begin
                any_grant = 1'b1;
                last_idx  = port_idx[k];
            end
        end
        next_rr = (last_idx == LAST_IDX) ? '0 : last_idx + 1'b1;
    end

    always_comb begin
        bus.fu_cdb_gnts = kill ? '0 : taken[N_CDB];
        for (int k = 0; k < N_CDB; k++) begin
            bus.cdb_ports[k] = (!kill && port_found[k]) ? bus.fu_results[port_idx[k]] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rr_ptr <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                starve_cnt[i] <= '0;
            end
        end else begin
            if (any_grant) begin
                rr_ptr <= next_rr;
            end
            // Counters saturate rather than wrap so a starved requester stays starved.
            for (int i = 0; i < N_REQ; i++) begin
                if (valid[i] && !taken[N_CDB][i]) begin
                    if (starve_cnt[i] != CNT_MAX) begin
                        starve_cnt[i] <= starve_cnt[i] + 1'b1;
                    end
                end else begin
                    starve_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!kill) begin
            assert ((bus.fu_cdb_gnts & ~valid) == '0);
            assert ($countones(bus.fu_cdb_gnts) ==
                    (($countones(valid) < N_CDB) ? $countones(valid) : N_CDB));
            for (int k = 0; k < N_CDB; k++) begin
                assert ($onehot0(port_pick[k]));
                if (k > 0) begin
                    assert (!port_found[k] || port_found[k-1]);
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic against
// a list-based priority model, on a default instance and a STARVE_LIMIT=1 instance.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N = NUM_FU;
    localparam int C = NUM_CDB;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    cdb_arbiter_if ifa ();
    cdb_arbiter_if ifb ();

    cdb_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (ifa.slave)
    );

    cdb_arbiter #(.STARVE_LIMIT(1)) dut_lim (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (ifb.slave)
    );

    int total  = 0;
    int passed = 0;

    writeback_packet_t fu_in [N];
    int                m_rr   [2];
    int                m_cnt  [2][N];
    int                m_last [2];
    int                lim    [2] = '{7, 1};
    logic [N-1:0]      exp_gnt  [2];
    writeback_packet_t exp_port [2][C];

    task automatic drive(input logic [N-1:0] mask, input logic f, input logic r);
        writeback_packet_t pkt;
        for (int i = 0; i < N; i++) begin
            pkt.is_valid  = mask[i];
            pkt.rob_tag   = ROB_TAG_W'($urandom);
            pkt.dest_preg = PREG_W'($urandom);
            pkt.data      = $urandom;
            fu_in[i]          = pkt;
            ifa.fu_results[i] = pkt;
            ifb.fu_results[i] = pkt;
        end
        flush = f;
        rst   = r;
    endtask

    // Model: list starved requesters in rotation order, then the rest; first C win.
    task automatic model_eval(input int inst);
        int order[$];
        int idx;
        exp_gnt[inst] = '0;
        for (int p = 0; p < C; p++) exp_port[inst][p] = '0;
        if (rst || flush) return;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr[inst] + k) % N;
                if (fu_in[idx].is_valid && ((m_cnt[inst][idx] == lim[inst]) == (pass == 0)))
                    order.push_back(idx);
            end
        end
        for (int p = 0; p < C && p < order.size(); p++) begin
            exp_gnt[inst][order[p]] = 1'b1;
            exp_port[inst][p]       = fu_in[order[p]];
            m_last[inst]            = order[p];
        end
    endtask

    task automatic model_commit(input int inst);
        if (rst || flush) begin
            m_rr[inst] = 0;
            for (int i = 0; i < N; i++) m_cnt[inst][i] = 0;
            return;
        end
        if (exp_gnt[inst] != '0) m_rr[inst] = (m_last[inst] + 1) % N;
        for (int i = 0; i < N; i++) begin
            if (fu_in[i].is_valid && !exp_gnt[inst][i])
                m_cnt[inst][i] = (m_cnt[inst][i] < lim[inst]) ? m_cnt[inst][i] + 1 : lim[inst];
            else
                m_cnt[inst][i] = 0;
        end
    endtask

    task automatic advance();
        model_commit(0);
        model_commit(1);
        @(posedge clk);
        #1;
    endtask

    task automatic settle_and_model();
        #2;
        model_eval(0);
        model_eval(1);
    endtask

    task automatic test_reset();
        drive('1, 1'b0, 1'b1);
        settle_and_model();
        total++;
        if (ifa.fu_cdb_gnts !== '0) $display("[TB] FAIL reset_gnt got %b want 0", ifa.fu_cdb_gnts);
        else passed++;
        for (int p = 0; p < C; p++) begin
            total++;
            if (ifa.cdb_ports[p] !== '0)
                $display("[TB] FAIL reset_port%0d got %h want 0", p, ifa.cdb_ports[p]);
            else passed++;
        end
        total++;
        if (ifb.fu_cdb_gnts !== '0) $display("[TB] FAIL reset_gnt_lim got %b want 0", ifb.fu_cdb_gnts);
        else passed++;
        advance();

        drive('1, 1'b0, 1'b0);
        settle_and_model();
        total++;
        if (ifa.fu_cdb_gnts !== 5'b00011)
            $display("[TB] FAIL release_gnt got %b want 00011", ifa.fu_cdb_gnts);
        else passed++;
        total++;
        if (ifa.cdb_ports[0] !== fu_in[0] || ifa.cdb_ports[1] !== fu_in[1])
            $display("[TB] FAIL release_ports got %h/%h want %h/%h",
                     ifa.cdb_ports[0], ifa.cdb_ports[1], fu_in[0], fu_in[1]);
        else passed++;
        total++;
        if (ifb.fu_cdb_gnts !== exp_gnt[1])
            $display("[TB] FAIL release_gnt_lim got %b want %b", ifb.fu_cdb_gnts, exp_gnt[1]);
        else passed++;
        advance();
    endtask

    task automatic test_rr_wrap();
        logic [N-1:0] want_gnt [4];
        int           want_first [4];
        want_gnt   = '{5'b00011, 5'b00101, 5'b00110, 5'b00011};
        want_first = '{0, 2, 1, 0};
        drive('1, 1'b0, 1'b1);
        settle_and_model();
        advance();
        for (int c = 0; c < 4; c++) begin
            drive(5'b00111, 1'b0, 1'b0);
            settle_and_model();
            total++;
            if (ifa.fu_cdb_gnts !== want_gnt[c])
                $display("[TB] FAIL rr_wrap_gnt c%0d got %b want %b", c, ifa.fu_cdb_gnts, want_gnt[c]);
            else passed++;
            total++;
            if (ifa.cdb_ports[0] !== fu_in[want_first[c]])
                $display("[TB] FAIL rr_wrap_port0 c%0d got %h want %h",
                         c, ifa.cdb_ports[0], fu_in[want_first[c]]);
            else passed++;
            total++;
            if (ifb.fu_cdb_gnts !== exp_gnt[1])
                $display("[TB] FAIL rr_wrap_gnt_lim c%0d got %b want %b", c, ifb.fu_cdb_gnts, exp_gnt[1]);
            else passed++;
            advance();
        end
    endtask

    task automatic test_single();
        drive('1, 1'b0, 1'b1);
        settle_and_model();
        advance();
        drive(5'b00100, 1'b0, 1'b0);
        settle_and_model();
        total++;
        if (ifa.fu_cdb_gnts !== 5'b00100 || ifa.cdb_ports[0] !== fu_in[2] || ifa.cdb_ports[1].is_valid !== 1'b0)
            $display("[TB] FAIL single got gnt=%b p0=%h p1v=%b want 00100/%h/0",
                     ifa.fu_cdb_gnts, ifa.cdb_ports[0], ifa.cdb_ports[1].is_valid, fu_in[2]);
        else passed++;
        advance();
        drive('1, 1'b0, 1'b0);
        settle_and_model();
        total++;
        if (ifa.fu_cdb_gnts !== 5'b11000 || ifa.cdb_ports[0] !== fu_in[3] || ifa.cdb_ports[1] !== fu_in[4])
            $display("[TB] FAIL single_next_ptr got gnt=%b want 11000", ifa.fu_cdb_gnts);
        else passed++;
        advance();
    endtask

    task automatic test_starvation();
        logic [N-1:0] want_gnt [4];
        want_gnt = '{5'b00011, 5'b01100, 5'b10001, 5'b00110};
        drive('1, 1'b0, 1'b1);
        settle_and_model();
        advance();
        for (int c = 0; c < 4; c++) begin
            drive('1, 1'b0, 1'b0);
            settle_and_model();
            total++;
            if (ifb.fu_cdb_gnts !== want_gnt[c])
                $display("[TB] FAIL starve_gnt_lim c%0d got %b want %b", c, ifb.fu_cdb_gnts, want_gnt[c]);
            else passed++;
            total++;
            if (ifa.fu_cdb_gnts !== exp_gnt[0])
                $display("[TB] FAIL starve_gnt c%0d got %b want %b", c, ifa.fu_cdb_gnts, exp_gnt[0]);
            else passed++;
            if (c == 2) begin
                total++;
                if (ifb.cdb_ports[0] !== fu_in[4])
                    $display("[TB] FAIL starve_port0_lim got %h want %h", ifb.cdb_ports[0], fu_in[4]);
                else passed++;
            end
            advance();
        end
    endtask

    task automatic test_flush();
        drive('1, 1'b0, 1'b1);
        settle_and_model();
        advance();
        drive('1, 1'b0, 1'b0);
        settle_and_model();
        advance();
        drive(5'b00011, 1'b1, 1'b0);
        settle_and_model();
        total++;
        if (ifa.fu_cdb_gnts !== '0 || ifa.cdb_ports[0] !== '0 || ifa.cdb_ports[1] !== '0)
            $display("[TB] FAIL flush_outputs got gnt=%b p0=%h", ifa.fu_cdb_gnts, ifa.cdb_ports[0]);
        else passed++;
        total++;
        if (ifb.fu_cdb_gnts !== '0) $display("[TB] FAIL flush_gnt_lim got %b want 0", ifb.fu_cdb_gnts);
        else passed++;
        advance();
        drive('1, 1'b0, 1'b0);
        settle_and_model();
        total++;
        if (ifa.fu_cdb_gnts !== 5'b00011 || ifa.cdb_ports[0] !== fu_in[0])
            $display("[TB] FAIL after_flush got gnt=%b want 00011", ifa.fu_cdb_gnts);
        else passed++;
        total++;
        if (ifb.fu_cdb_gnts !== 5'b00011)
            $display("[TB] FAIL after_flush_lim got gnt=%b want 00011", ifb.fu_cdb_gnts);
        else passed++;
        advance();
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        logic         f;
        logic         r;
        for (int c = 0; c < 400; c++) begin
            mask = N'($urandom);
            f    = ($urandom_range(0, 19) == 0);
            r    = ($urandom_range(0, 99) == 0);
            drive(mask, f, r);
            settle_and_model();
            total++;
            if (ifa.fu_cdb_gnts !== exp_gnt[0] || ifb.fu_cdb_gnts !== exp_gnt[1])
                $display("[TB] FAIL random_gnt c%0d got %b/%b want %b/%b",
                         c, ifa.fu_cdb_gnts, ifb.fu_cdb_gnts, exp_gnt[0], exp_gnt[1]);
            else passed++;
            for (int p = 0; p < C; p++) begin
                total++;
                if (ifa.cdb_ports[p] !== exp_port[0][p] || ifb.cdb_ports[p] !== exp_port[1][p])
                    $display("[TB] FAIL random_port%0d c%0d got %h/%h want %h/%h", p, c,
                             ifa.cdb_ports[p], ifb.cdb_ports[p], exp_port[0][p], exp_port[1][p]);
                else passed++;
            end
            advance();
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_rr[i]   = 0;
            m_last[i] = 0;
            for (int j = 0; j < N; j++) m_cnt[i][j] = 0;
        end
        test_reset();
        test_rr_wrap();
        test_single();
        test_starvation();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
